// File: rtl/operand_fetch_pkg.sv
// Shared types and constants for the operand-fetch stage and its busy scoreboard.
package opfetch_pkg;

  localparam int DATA_W = 32;
  localparam int IDX_W  = 5;
  localparam int NREG   = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READ  = 2'd2,
    VALID = 2'd3
  } state_t;

  typedef struct packed {
    logic [IDX_W-1:0] rs1;
    logic [IDX_W-1:0] rs2;
    logic [IDX_W-1:0] rd;
    logic             rs1_en;
    logic             rs2_en;
    logic             rd_en;
  } instr_t;

endpackage

// File: rtl/operand_fetch_scoreboard.sv
// reg_scoreboard: one busy bit per architectural register. x0 is never busy.
// A set and a clear of the same register on the same edge leave it busy.
module reg_scoreboard import opfetch_pkg::*; (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_en,
  input  logic [IDX_W-1:0] set_idx,
  input  logic             clr_en,
  input  logic [IDX_W-1:0] clr_idx,
  input  logic [IDX_W-1:0] look_idx1,
  input  logic [IDX_W-1:0] look_idx2,
  output logic [NREG-1:0]  busy,
  output logic             look_busy1,
  output logic             look_busy2
);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_nxt;

  // Set is applied after clear so the newer producer stays pending.
  always_comb begin
    w_busy_nxt = r_busy;
    if (clr_en) w_busy_nxt[clr_idx] = 1'b0;
    if (set_en) w_busy_nxt[set_idx] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= w_busy_nxt;
  end

  assign busy       = r_busy;
  assign look_busy1 = r_busy[look_idx1];
  assign look_busy2 = r_busy[look_idx2];

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: accepts decoded instructions, stalls on RAW hazards via the busy
// scoreboard, reads operands from the register file and turns writebacks into rf writes.
// Optional writeback capture in WAIT is enabled by defining OPFETCH_BYPASS_EN.
//
// state | meaning
// IDLE  | ready to accept an instruction from decode
// WAIT  | a needed source is still pending a writeback
// READ  | register-file read request driven this cycle
// VALID | operands presented to execute until accepted
module operand_fetch import opfetch_pkg::*; (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [IDX_W-1:0]  id_rs1,
  input  logic [IDX_W-1:0]  id_rs2,
  input  logic [IDX_W-1:0]  id_rd,
  input  logic              id_rs1_en,
  input  logic              id_rs2_en,
  input  logic              id_rd_en,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [DATA_W-1:0] ex_op1,
  output logic [DATA_W-1:0] ex_op2,
  output logic [IDX_W-1:0]  ex_rd,
  output logic              ex_rd_en,
  input  logic              wb_valid,
  input  logic [IDX_W-1:0]  wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic [IDX_W-1:0]  rf_read_reg1,
  output logic [IDX_W-1:0]  rf_read_reg2,
  output logic              rf_read_en1,
  output logic              rf_read_en2,
  input  logic [DATA_W-1:0] rf_read_data1,
  input  logic [DATA_W-1:0] rf_read_data2,
  output logic [IDX_W-1:0]  rf_write_reg,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_write_en,
  output logic [NREG-1:0]   busy_o
);

  state_t            r_state;
  instr_t            r_ins;
  logic              r_res1, r_res2;
  logic [DATA_W-1:0] r_op1, r_op2;
  logic              r_rd_en1, r_rd_en2;
  logic [IDX_W-1:0]  r_rd_reg1, r_rd_reg2;
  logic              r_wr_en;
  logic [IDX_W-1:0]  r_wr_reg;
  logic [DATA_W-1:0] r_wr_data;

  logic             w_idle, w_wait, w_handshake;
  logic [IDX_W-1:0] w_lk1, w_lk2;
  logic             w_busy1, w_busy2;
  logic             w_need1, w_need2;
  logic             w_hit1, w_hit2;
  logic             w_res1, w_res2;
  logic             w_stall, w_all_byp;

  assign w_idle      = (r_state == IDLE);
  assign w_wait      = (r_state == WAIT);
  assign w_handshake = (r_state == VALID) & ex_ready;

  // Hazard lookup uses the incoming fields in IDLE and the latched ones otherwise.
  assign w_lk1   = w_idle ? id_rs1 : r_ins.rs1;
  assign w_lk2   = w_idle ? id_rs2 : r_ins.rs2;
  assign w_need1 = w_idle ? (id_rs1_en & (id_rs1 != '0)) : (r_ins.rs1_en & (r_ins.rs1 != '0));
  assign w_need2 = w_idle ? (id_rs2_en & (id_rs2 != '0)) : (r_ins.rs2_en & (r_ins.rs2 != '0));

`ifdef OPFETCH_BYPASS_EN
  assign w_hit1 = w_wait & wb_valid & w_need1 & w_busy1 & ~r_res1 & (wb_rd == r_ins.rs1);
  assign w_hit2 = w_wait & wb_valid & w_need2 & w_busy2 & ~r_res2 & (wb_rd == r_ins.rs2);
`else
  assign w_hit1 = 1'b0;
  assign w_hit2 = 1'b0;
`endif

  assign w_res1    = r_res1 | w_hit1;
  assign w_res2    = r_res2 | w_hit2;
  assign w_stall   = (w_need1 & w_busy1 & ~w_res1) | (w_need2 & w_busy2 & ~w_res2);
  assign w_all_byp = (~w_need1 | w_res1) & (~w_need2 | w_res2) & (w_res1 | w_res2);

  reg_scoreboard u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_en     (w_handshake & r_ins.rd_en),
    .set_idx    (r_ins.rd),
    .clr_en     (r_wr_en),
    .clr_idx    (r_wr_reg),
    .look_idx1  (w_lk1),
    .look_idx2  (w_lk2),
    .busy       (busy_o),
    .look_busy1 (w_busy1),
    .look_busy2 (w_busy2)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ins     <= '0;
      r_res1    <= 1'b0;
      r_res2    <= 1'b0;
      r_op1     <= '0;
      r_op2     <= '0;
      r_rd_en1  <= 1'b0;
      r_rd_en2  <= 1'b0;
      r_rd_reg1 <= '0;
      r_rd_reg2 <= '0;
      r_wr_en   <= 1'b0;
      r_wr_reg  <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= 1'b0;
      if (wb_valid && wb_rd != '0) begin
        r_wr_en   <= 1'b1;
        r_wr_reg  <= wb_rd;
        r_wr_data <= wb_data;
      end

      case (r_state)
        IDLE: begin
          if (id_valid) begin
            r_ins  <= '{rs1: id_rs1, rs2: id_rs2, rd: id_rd,
                        rs1_en: id_rs1_en, rs2_en: id_rs2_en, rd_en: id_rd_en};
            r_op1  <= '0;
            r_op2  <= '0;
            r_res1 <= 1'b0;
            r_res2 <= 1'b0;
            if (w_stall) begin
              r_state <= WAIT;
            end else begin
              r_state   <= READ;
              r_rd_en1  <= id_rs1_en;
              r_rd_en2  <= id_rs2_en;
              r_rd_reg1 <= id_rs1;
              r_rd_reg2 <= id_rs2;
            end
          end
        end
        WAIT: begin
          if (w_hit1) begin
            r_op1  <= wb_data;
            r_res1 <= 1'b1;
          end
          if (w_hit2) begin
            r_op2  <= wb_data;
            r_res2 <= 1'b1;
          end
          if (!w_stall) begin
            if (w_all_byp) begin
              r_state <= VALID;
            end else begin
              r_state   <= READ;
              r_rd_en1  <= r_ins.rs1_en & ~w_res1;
              r_rd_en2  <= r_ins.rs2_en & ~w_res2;
              r_rd_reg1 <= r_ins.rs1;
              r_rd_reg2 <= r_ins.rs2;
            end
          end
        end
        READ: begin
          r_rd_en1 <= 1'b0;
          r_rd_en2 <= 1'b0;
          if (!r_res1) r_op1 <= w_need1 ? rf_read_data1 : '0;
          if (!r_res2) r_op2 <= w_need2 ? rf_read_data2 : '0;
          r_state <= VALID;
        end
        VALID: begin
          if (ex_ready) begin
            r_state <= IDLE;
            r_res1  <= 1'b0;
            r_res2  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign id_ready      = w_idle & rst_n;
  assign ex_valid      = (r_state == VALID);
  assign ex_op1        = r_op1;
  assign ex_op2        = r_op2;
  assign ex_rd         = r_ins.rd;
  assign ex_rd_en      = r_ins.rd_en;
  assign rf_read_en1   = r_rd_en1;
  assign rf_read_en2   = r_rd_en2;
  assign rf_read_reg1  = r_rd_reg1;
  assign rf_read_reg2  = r_rd_reg2;
  assign rf_write_en   = r_wr_en;
  assign rf_write_reg  = r_wr_reg;
  assign rf_write_data = r_wr_data;

endmodule
